// File: rtl/control_pipe.sv
// rtl/control_pipe.sv - decode-to-execute control register with load-use interlock
//
// Decodes the instruction code presented by the decode stage, holds the
// resulting control word in a single EX register and stalls the decode stage
// for one cycle when a source register depends on a load sitting in EX.
//
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   id_valid / id_ready              decode-stage handshake
//   id_code, id_rd, id_rj, id_rk     decoded code and register addresses
//   id_rj_use, id_rk_use             source operand actually read
//   flush                            drop held and presented instructions
//   ex_valid / ex_ready              execute-stage handshake
//   ex_alu_ctrl, ex_mem_read, ex_mem_write, ex_rf_write,
//   ex_branch, ex_illegal, ex_rd     registered control word
//   perf_stall_cnt                   saturating load-use stall counter
module control_pipe #(
  parameter int CODE_W = 6,
  parameter int ALU_W  = 5,
  parameter int RA_W   = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  output logic              id_ready,
  input  logic [CODE_W-1:0] id_code,
  input  logic [RA_W-1:0]   id_rd,
  input  logic [RA_W-1:0]   id_rj,
  input  logic [RA_W-1:0]   id_rk,
  input  logic              id_rj_use,
  input  logic              id_rk_use,
  input  logic              flush,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [ALU_W-1:0]  ex_alu_ctrl,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_rf_write,
  output logic              ex_branch,
  output logic              ex_illegal,
  output logic [RA_W-1:0]   ex_rd,
  output logic [CNT_W-1:0]  perf_stall_cnt
);

  logic             ex_valid_q;
  logic [ALU_W-1:0] ex_alu_q;
  logic             ex_mr_q, ex_mw_q, ex_rf_q, ex_br_q, ex_il_q;
  logic [RA_W-1:0]  ex_rd_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] stall_cnt_d;

  logic [31:0]      code;
  logic [7:0]       alu8;
  logic             dec_mr, dec_mw, dec_rf, dec_br, dec_il;
  logic             advance, hazard, stall_evt;

  assign code = 32'(id_code);

  always_comb begin
    alu8   = 8'h00;
    dec_mr = 1'b0;
    dec_mw = 1'b0;
    dec_rf = 1'b0;
    dec_br = 1'b0;
    dec_il = 1'b0;
    if (code > 32'h27) begin
      dec_il = 1'b1;
    end else begin
      if (code <= 32'h09) begin
        alu8 = code[7:0];
      end else if (code >= 32'h1e && code <= 32'h23) begin
        alu8 = code[7:0] - 8'h08;  // branch group maps 1e..23 onto 16..1b
      end else begin
        case (code[7:0])
          8'h0a: alu8 = 8'h0d;
          8'h0b: alu8 = 8'h0a;
          8'h0c: alu8 = 8'h0e;
          8'h0d: alu8 = 8'h0b;
          8'h0e: alu8 = 8'h0c;
          8'h0f: alu8 = 8'h0f;
          8'h10: alu8 = 8'h10;
          8'h11: alu8 = 8'h13;
          8'h12: alu8 = 8'h11;
          8'h13: alu8 = 8'h14;
          8'h14: alu8 = 8'h12;
          8'h15: alu8 = 8'h15;
          8'h25: alu8 = 8'h1c;
          8'h26: alu8 = 8'h1d;
          default: alu8 = 8'h00;
        endcase
      end
      dec_mr = (code >= 32'h19 && code <= 32'h1d);
      dec_mw = (code >= 32'h16 && code <= 32'h18);
      dec_rf = (code <= 32'h15) || (code >= 32'h19 && code <= 32'h1d) ||
               (code == 32'h25) || (code == 32'h26);
      dec_br = (code >= 32'h1e && code <= 32'h26);
    end
  end

  assign advance = !ex_valid_q || ex_ready;
  // Only a valid load with a non-zero destination can create a load-use stall.
  assign hazard  = ex_valid_q && ex_mr_q && (ex_rd_q != '0) &&
                   ((id_rj_use && (id_rj == ex_rd_q)) ||
                    (id_rk_use && (id_rk == ex_rd_q)));
  // rst_n gating keeps id_ready low while reset is held.
  assign id_ready  = rst_n && advance && !hazard && !flush;
  assign stall_evt = id_valid && hazard && advance && !flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_evt && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q  <= 1'b0;
      ex_alu_q    <= '0;
      ex_mr_q     <= 1'b0;
      ex_mw_q     <= 1'b0;
      ex_rf_q     <= 1'b0;
      ex_br_q     <= 1'b0;
      ex_il_q     <= 1'b0;
      ex_rd_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      // Flags are left untouched whenever ex_valid drops; consumers qualify.
      if (flush) begin
        ex_valid_q <= 1'b0;
      end else if (!advance) begin
        ex_valid_q <= ex_valid_q;
      end else if (hazard) begin
        ex_valid_q <= 1'b0;
      end else if (id_valid) begin
        ex_valid_q <= 1'b1;
        ex_alu_q   <= ALU_W'(alu8);
        ex_mr_q    <= dec_mr;
        ex_mw_q    <= dec_mw;
        ex_rf_q    <= dec_rf;
        ex_br_q    <= dec_br;
        ex_il_q    <= dec_il;
        ex_rd_q    <= id_rd;
      end else begin
        ex_valid_q <= 1'b0;
      end
    end
  end

  assign ex_valid       = ex_valid_q;
  assign ex_alu_ctrl    = ex_alu_q;
  assign ex_mem_read    = ex_mr_q;
  assign ex_mem_write   = ex_mw_q;
  assign ex_rf_write    = ex_rf_q;
  assign ex_branch      = ex_br_q;
  assign ex_illegal     = ex_il_q;
  assign ex_rd          = ex_rd_q;
  assign perf_stall_cnt = stall_cnt_q;

endmodule

// File: doc/control_pipe.md
CONTROL_PIPE -- requirements
Module: control_pipe

Interface
REQ-001 SHALL have parameter CODE_W, default 6, meaning width of the decoded instruction code.
REQ-002 SHALL have parameter ALU_W, default 5, meaning width of the ALU operation code.
REQ-003 SHALL have parameter RA_W, default 5, meaning register-address width.
REQ-004 SHALL have parameter CNT_W, default 16, meaning stall-counter width.
REQ-005 SHALL have one clock and an asynchronous active-low reset, with the following ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  decode stage presents an instruction.
- id_ready  out  1  control stage accepts the instruction this cycle.
- id_code  in  CODE_W  decoded instruction code.
- id_rd, id_rj, id_rk  in  RA_W each  destination and source register addresses.
- id_rj_use, id_rk_use  in  1 each  source operand is actually read.
- flush  in  1  discard the held and the presented instruction.
- ex_valid  out  1  execute-stage control word is valid.
- ex_ready  in  1  execute stage consumes the control word this cycle.
- ex_alu_ctrl  out  ALU_W  ALU operation.
- ex_mem_read, ex_mem_write, ex_rf_write, ex_branch, ex_illegal  out  1 each  control flags.
- ex_rd  out  RA_W  destination register.
- perf_stall_cnt  out  CNT_W  load-use stall cycle count.

Function
REQ-006 SHALL decode id_code combinationally and register the result in the EX register when the EX register loads.
- alu_ctrl, codes 0x00–0x09: op equals code.
- alu_ctrl, other codes: 0a→0d, 0b→0a, 0c→0e, 0d→0b, 0e→0c, 0f→0f, 10→10, 11→13, 12→11, 13→14, 14→12, 15→15.
- alu_ctrl, branch and jump codes: 1e..23→16..1b, 25→1c, 26→1d.
- alu_ctrl, all other codes: 00.
REQ-007 SHALL set the remaining decode flags by code range:
- mem_read = code in 0x19–0x1d.
- mem_write = code in 0x16–0x18.
- rf_write = code in 0x00–0x15, 0x19–0x1d, 0x25 or 0x26.
- branch = code in 0x1e–0x26.
- illegal = code > 0x27; all other flags 0 and alu 00 for illegal codes.
REQ-008 SHALL define advance = !ex_valid | ex_ready.
REQ-009 SHALL define hazard = ex_valid & ex_mem_read & (ex_rd != 0) & ((id_rj_use & id_rj == ex_rd) | (id_rk_use & id_rk == ex_rd)).
REQ-010 SHALL drive id_ready = advance & !hazard & !flush, combinationally.
REQ-011 SHALL update the EX register on each clock edge by the first matching row:
- flush: ex_valid <= 0.
- !advance: hold all EX outputs.
- hazard: ex_valid <= 0, which inserts a one-cycle bubble.
- id_valid: load decoded fields and id_rd, ex_valid <= 1.
- otherwise: ex_valid <= 0.
REQ-012 SHALL keep control flags at their previous values whenever ex_valid is 0; consumers qualify every flag with ex_valid.
REQ-013 SHALL give a one-cycle latency from an accepted instruction (id_valid & id_ready) to ex_valid = 1.
REQ-014 SHALL give flush priority over hazard, stall and load in the same cycle, with no instruction accepted.
REQ-015 SHALL never stall on a hazard where ex_rd = 0.
REQ-016 SHALL never stall on a hazard whose producer is not a load.
REQ-017 SHALL increment perf_stall_cnt by 1 in each cycle with id_valid & hazard & advance & !flush.
REQ-018 SHALL saturate perf_stall_cnt at 2^CNT_W−1 and never wrap.
REQ-019 SHALL sustain one instruction per cycle when ex_ready = 1 and no hazard occurs.

Reset
REQ-020 SHALL, while rst_n = 0, asynchronously force ex_valid, ex_alu_ctrl, all flags, ex_rd and perf_stall_cnt to 0.
REQ-021 SHALL drive id_ready = 0 during reset.
REQ-022 SHALL, on reset assertion mid-stall, discard the held instruction and resume with an empty EX register after release.

Verification
REQ-023 SHALL cover back-to-back streaming: codes 0x00, 0x0b, 0x11 at id_valid=1 with ex_ready=1 -> ex_alu_ctrl 00, 0a, 13 on consecutive cycles; rf_write=1 on all three.
REQ-024 SHALL cover load-use: ld.w (0x19) with rd=5, then add (0x00) with rj=5 and rj_use=1 -> id_ready=0 for one cycle, one bubble, add issues a cycle later, perf_stall_cnt=1.
REQ-025 SHALL cover the zero-register case: ld.w with rd=0, then add with rj=0 -> no stall, perf_stall_cnt stays 0.
REQ-026 SHALL cover backpressure then flush: ex_ready=0 for 3 cycles holding st.w (0x16, mem_write=1), then flush=1 -> ex_valid=0 next cycle, id_ready=0 during flush.
REQ-027 SHALL cover an illegal code: id_code 0x30 -> ex_illegal=1, ex_rf_write=0, ex_alu_ctrl=00.
REQ-028 SHALL cover the saturation bound: CNT_W=2 with 5 consecutive hazard cycles -> perf_stall_cnt=3; rst_n pulse -> 0.
